// File: rtl/master_port.sv
// Bit-serial bus initiator. Local requests are shifted out MSB-first on wr_bus,
// and read data is shifted in from rd_bus. Every bit moves under a valid/ready handshake.
module master_port #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mode,
    output logic                  wr_bus,
    output logic                  master_valid,
    output logic                  master_ready,
    input  logic                  rd_bus,
    input  logic                  slave_ready,
    input  logic                  slave_valid
);
    localparam int SW   = ADDR_WIDTH + DATA_WIDTH;
    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RX, S_GAP} state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         sh_q, sh_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [CW-1:0]         bit_q, bit_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  mode_q, mode_d;
    logic                  wr_bus_q, wr_bus_d;
    logic                  master_valid_q, master_valid_d;
    logic                  master_ready_q, master_ready_d;

    logic                  hs;
    logic                  to_gap;
    logic                  gap_err;
    logic [DATA_WIDTH-1:0] gap_rdata;
    logic [CW-1:0]         phase_last;

    assign hs         = master_valid_q && slave_ready;
    assign phase_last = (state_q == S_ADDR) ? ADDR_LAST : DATA_LAST;

    always_comb begin
        state_d        = state_q;
        sh_d           = sh_q;
        rx_d           = rx_q;
        bit_d          = bit_q;
        tmo_d          = tmo_q;
        req_ready_d    = 1'b0;
        resp_valid_d   = 1'b0;
        resp_err_d     = resp_err_q;
        resp_rdata_d   = resp_rdata_q;
        mode_d         = 1'b0;
        wr_bus_d       = 1'b0;
        master_valid_d = 1'b0;
        master_ready_d = 1'b0;
        to_gap         = 1'b0;
        gap_err        = 1'b0;
        gap_rdata      = '0;

        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    state_d        = S_ADDR;
                    sh_d           = {req_addr, req_wdata};
                    bit_d          = '0;
                    tmo_d          = '0;
                    req_ready_d    = 1'b0;
                    mode_d         = req_wr;
                    master_valid_d = 1'b1;
                    wr_bus_d       = req_addr[ADDR_WIDTH-1];
                end
            end
            S_ADDR, S_DATA: begin
                mode_d         = mode_q;
                master_valid_d = 1'b1;
                wr_bus_d       = wr_bus_q;
                if (hs) begin
                    // sh_q[SW-2] is the bit that becomes MSB after this shift
                    sh_d     = sh_q << 1;
                    tmo_d    = '0;
                    wr_bus_d = sh_q[SW-2];
                    bit_d    = bit_q + CW'(1);
                    if (bit_q == phase_last) begin
                        bit_d = '0;
                        if (state_q == S_DATA) begin
                            to_gap = 1'b1;
                        end else if (mode_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d        = S_RX;
                            rx_d           = '0;
                            master_valid_d = 1'b0;
                            master_ready_d = 1'b1;
                            wr_bus_d       = 1'b0;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    to_gap  = 1'b1;
                    gap_err = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RX: begin
                mode_d         = mode_q;
                master_ready_d = 1'b1;
                if (slave_valid) begin
                    rx_d  = {rx_q[DATA_WIDTH-2:0], rd_bus};
                    tmo_d = '0;
                    bit_d = bit_q + CW'(1);
                    if (bit_q == DATA_LAST) begin
                        to_gap    = 1'b1;
                        gap_rdata = {rx_q[DATA_WIDTH-2:0], rd_bus};
                    end
                end else if (tmo_q == TMO_LAST) begin
                    to_gap  = 1'b1;
                    gap_err = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_GAP: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase

        // GAP quiets the bus for one cycle and carries the response pulse
        if (to_gap) begin
            state_d        = S_GAP;
            bit_d          = '0;
            tmo_d          = '0;
            mode_d         = 1'b0;
            wr_bus_d       = 1'b0;
            master_valid_d = 1'b0;
            master_ready_d = 1'b0;
            resp_valid_d   = 1'b1;
            resp_err_d     = gap_err;
            resp_rdata_d   = gap_rdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            sh_q           <= '0;
            rx_q           <= '0;
            bit_q          <= '0;
            tmo_q          <= '0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_rdata_q   <= '0;
            mode_q         <= 1'b0;
            wr_bus_q       <= 1'b0;
            master_valid_q <= 1'b0;
            master_ready_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sh_q           <= sh_d;
            rx_q           <= rx_d;
            bit_q          <= bit_d;
            tmo_q          <= tmo_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_err_q     <= resp_err_d;
            resp_rdata_q   <= resp_rdata_d;
            mode_q         <= mode_d;
            wr_bus_q       <= wr_bus_d;
            master_valid_q <= master_valid_d;
            master_ready_q <= master_ready_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_err     = resp_err_q;
    assign resp_rdata   = resp_rdata_q;
    assign mode         = mode_q;
    assign wr_bus       = wr_bus_q;
    assign master_valid = master_valid_q;
    assign master_ready = master_ready_q;
endmodule

// File: doc/master_port.md
# master_port

Bit-serial bus initiator: accepts parallel read/write requests from a local master device and serialises them onto the system bus towards a slave port. Address and write data go out MSB-first on `wr_bus`. Read data comes back MSB-first on `rd_bus`. Every bit moves under a valid/ready handshake. A completed transaction returns to the local side as a one-cycle response pulse.

## Interface
- `ADDR_WIDTH`, 16, address bits per transaction.
- `DATA_WIDTH`, 8, data bits per transaction.
- `TIMEOUT`, 32, maximum consecutive cycles without a bit handshake before the transaction is abandoned (≥2).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, all state on rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  local request present.
- `req_ready`  out  1  port can accept a request.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  target address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  qualifies `resp_valid`; 1 = timeout.
- `resp_rdata`  out  DATA_WIDTH  read data; valid with `resp_valid` on reads.
- `mode`  out  1  bus transaction type; equals latched `req_wr`.
- `wr_bus`  out  1  serial address/write-data bit.
- `master_valid`  out  1  `wr_bus` bit valid.
- `master_ready`  out  1  initiator accepting `rd_bus` bits.
- `rd_bus`  in  1  serial read-data bit.
- `slave_ready`  in  1  slave accepting `wr_bus` bits.
- `slave_valid`  in  1  `rd_bus` bit valid.

## Operation
- States:
  - IDLE: `req_ready` = 1, all bus outputs 0.
  - On `req_valid`: latch `req_wr`, `req_addr`, `req_wdata` into shift registers, then go to ADDR.
- ADDR:
  - `master_valid` = 1, `mode` = latched wr, `wr_bus` = current address MSB.
  - Bit handshake = `master_valid && slave_ready` at a clock edge: shift left, increment bit counter.
  - After ADDR_WIDTH handshakes: go to DATA if write, RX if read.
- DATA:
  - Same as ADDR, driving write-data MSB-first.
  - After DATA_WIDTH handshakes, go to GAP with a success response.
- RX:
  - `master_valid` = 0, `master_ready` = 1.
  - Each edge with `slave_valid` = 1: `rdata <= {rdata[DATA_WIDTH-2:0], rd_bus}`, increment counter.
  - After DATA_WIDTH samples, go to GAP with a success response.
- GAP:
  - Lasts exactly one cycle: `resp_valid` = 1, all bus outputs 0. Then go to IDLE.
  - This guarantees ≥2 cycles with `master_valid` low between transactions (GAP + IDLE accept cycle).
- `master_valid` never drops mid-phase; the slave interprets that as an abort.
- `mode` stays stable from ADDR entry until GAP.
- Timeout:
  - An idle-cycle counter runs in ADDR/DATA/RX and clears on every bit handshake/sample and on phase entry.
  - When it reaches TIMEOUT: go to GAP with `resp_err` = 1 and `resp_rdata` = 0.
- Bit counter width is `$clog2(max(ADDR_WIDTH,DATA_WIDTH)+1)`; it clears on each phase entry.
- Timeout counter width is `$clog2(TIMEOUT+1)`.

## Timing
- All outputs are registered. Reset values: `req_ready` = 1 (IDLE), every other output 0.
- `rstn` low at any time forces IDLE and the reset values asynchronously. An in-flight transaction is dropped with no `resp_valid`.
- Request accepted in cycle N → `master_valid` = 1 with address MSB in cycle N+1.
- Write with `slave_ready` held 1:
  - ADDR_WIDTH+DATA_WIDTH cycles of `master_valid`.
  - `resp_valid` in cycle N+1+ADDR_WIDTH+DATA_WIDTH.
  - `req_ready` again in cycle N+2+ADDR_WIDTH+DATA_WIDTH.
- Read: `resp_valid` occurs one cycle after the edge that captures the last `rd_bus` bit.
- Simultaneous `req_valid` and GAP: not accepted; `req_ready` = 0 in GAP.
- `slave_ready` while `master_valid` = 0, and `slave_valid` outside RX, are ignored.
- `resp_err` and `resp_rdata` hold their values until the next `resp_valid`.

## Test plan
- Write 0x0005←0xA5 (16/8), `slave_ready` = 1 → `wr_bus` = 0000_0000_0000_0101 then 1010_0101 over 24 consecutive valid cycles, `mode` = 1, then `resp_valid` = 1 and `resp_err` = 0 at cycle 25 after acceptance.
- Read 0x0005 from a slave model returning 0xA5 with `slave_valid` bursty (1,0,1,1,…) → `master_valid` drops after 16 address bits, `master_ready` = 1, `resp_rdata` = 0xA5, `resp_err` = 0.
- Write with `slave_ready` toggling 1/0 → each `wr_bus` bit held stable until its handshake; slave receives 0x0005/0xA5; the transaction takes 48 cycles.
- `slave_ready` stuck 0, TIMEOUT = 32 → after 32 cycles in ADDR: `master_valid` = 0, `resp_valid` = 1, `resp_err` = 1, `resp_rdata` = 0.
- `rstn` pulsed low during the 4th data bit → all outputs at reset values immediately, no `resp_valid`; a following write of 0x0003←0x3C completes correctly.
- `req_valid` held high for two back-to-back writes → `req_ready` high only in IDLE; `master_valid` low for ≥2 cycles between the two transactions; two `resp_valid` pulses.
